// File: rtl/ld_req_issuer_pkg.sv
// Shared memory-subsystem types: front-end FSM, load-request issuer FSM, and ID counter width.
package pkg_mem;

  localparam int LD_REQ_ID_CNT_W = 2;

  typedef logic [LD_REQ_ID_CNT_W-1:0] ld_req_id_cnt_t;

  typedef enum logic [1:0] {
    MEM_FE_IDLE = 2'd0,
    MEM_FE_CMD  = 2'd1,
    MEM_FE_XFER = 2'd2,
    MEM_FE_RESP = 2'd3
  } fsm_memfe;

  typedef enum logic [3:0] {
    LD_REQ_INIT   = 4'd0,
    LD_REQ_ACQ    = 4'd1,
    LD_REQ_ID     = 4'd2,
    LD_REQ_ATTRIB = 4'd3,
    LD_REQ_RCFG   = 4'd4,
    LD_REQ_LENGTH = 4'd5,
    LD_REQ_STRIDE = 4'd6,
    LD_REQ_BASE   = 4'd7,
    LD_REQ_REPLY  = 4'd8,
    LD_REQ_DATA   = 4'd9,
    LD_REQ_RLS    = 4'd10,
    LD_REQ_DONE   = 4'd11
  } fsm_ldrq;

  // States that put a token on the request path and wait for it to be accepted.
  function automatic logic ld_req_is_emit(input fsm_ldrq s);
    case (s)
      LD_REQ_ACQ, LD_REQ_ID, LD_REQ_ATTRIB, LD_REQ_RCFG,
      LD_REQ_LENGTH, LD_REQ_STRIDE, LD_REQ_BASE, LD_REQ_RLS: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ld_req_issuer_if.sv
// Token bus between the load-request issuer (master) and the memory-side front end (slave).
interface ld_req_issuer_if
  import pkg_mem::*;
#(
  parameter int WIDTH = 32
);

  logic                       O_Valid;
  logic [WIDTH-1:0]           O_Data;
  logic                       O_Acq;
  logic                       O_Rls;
  logic [LD_REQ_ID_CNT_W-1:0] O_Reply_ID;
  logic                       I_Stall;
  logic                       I_Valid;
  logic [WIDTH-1:0]           I_Data;
  logic                       I_Term;

  modport master (
    output O_Valid, O_Data, O_Acq, O_Rls, O_Reply_ID,
    input  I_Stall, I_Valid, I_Data, I_Term
  );

  modport slave (
    input  O_Valid, O_Data, O_Acq, O_Rls, O_Reply_ID,
    output I_Stall, I_Valid, I_Data, I_Term
  );

endinterface

// File: rtl/ld_req_issuer.sv
// Load-request issuer: emits Acq, 3 IDs, descriptor words and Rls as tokens on the request path.
// Pull requests (reply-ID handshake and data wait) are compiled in only with LD_REQ_PULL_EN.
module ld_req_issuer
  import pkg_mem::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_IDS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Req,
  input  logic [WIDTH-1:0] I_MyID,
  input  logic [WIDTH-1:0] I_ID_T,
  input  logic [WIDTH-1:0] I_ID_F,
  input  logic [WIDTH-1:0] I_Attrib,
  input  logic [WIDTH-1:0] I_RConfig,
  input  logic [WIDTH-1:0] I_Length,
  input  logic [WIDTH-1:0] I_Stride,
  input  logic [WIDTH-1:0] I_Base,
  input  logic             I_PullReq,
  output logic             O_Busy,
  output logic             O_Done,
  ld_req_issuer_if.master  bus
);

  localparam ld_req_id_cnt_t LAST_ID = ld_req_id_cnt_t'(NUM_IDS - 1);
  localparam ld_req_id_cnt_t ID_ONE  = ld_req_id_cnt_t'(1);

  fsm_ldrq        state, state_nxt;
  ld_req_id_cnt_t id_cnt, id_cnt_nxt;
  logic           capture;
  logic           accept;
  logic           cap_pull;

  logic [WIDTH-1:0] cap_myid, cap_id_t, cap_id_f;
  logic [WIDTH-1:0] cap_attrib, cap_rcfg, cap_length, cap_stride, cap_base;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= LD_REQ_INIT;
      id_cnt     <= '0;
      cap_myid   <= '0;
      cap_id_t   <= '0;
      cap_id_f   <= '0;
      cap_attrib <= '0;
      cap_rcfg   <= '0;
      cap_length <= '0;
      cap_stride <= '0;
      cap_base   <= '0;
    end else begin
      state  <= state_nxt;
      id_cnt <= id_cnt_nxt;
      if (capture) begin
        cap_myid   <= I_MyID;
        cap_id_t   <= I_ID_T;
        cap_id_f   <= I_ID_F;
        cap_attrib <= I_Attrib;
        cap_rcfg   <= I_RConfig;
        cap_length <= I_Length;
        cap_stride <= I_Stride;
        cap_base   <= I_Base;
      end
    end
  end

`ifdef LD_REQ_PULL_EN
  logic pull_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pull_q <= 1'b0;
    end else if (capture) begin
      pull_q <= I_PullReq;
    end
  end

  assign cap_pull = pull_q;

  // Reply payload is consumed downstream; the issuer only sequences the handshake.
  logic unused_reply;
  assign unused_reply = ^bus.I_Data;
`else
  assign cap_pull = 1'b0;

  logic unused_reply;
  assign unused_reply = ^{bus.I_Data, bus.I_Valid, bus.I_Term, I_PullReq};
`endif

  assign bus.O_Valid = ld_req_is_emit(state);
  assign accept      = bus.O_Valid & ~bus.I_Stall;

  always_comb begin
    state_nxt      = state;
    id_cnt_nxt     = id_cnt;
    capture        = 1'b0;
    bus.O_Data     = '0;
    bus.O_Acq      = 1'b0;
    bus.O_Rls      = 1'b0;
    bus.O_Reply_ID = '0;
    O_Busy         = 1'b1;
    O_Done         = 1'b0;

    case (state)
      LD_REQ_INIT: begin
        O_Busy = 1'b0;
        if (I_Req) begin
          capture   = 1'b1;
          state_nxt = LD_REQ_ACQ;
        end
      end
      LD_REQ_ACQ: begin
        bus.O_Acq = 1'b1;
        if (accept) state_nxt = LD_REQ_ID;
      end
      LD_REQ_ID: begin
        case (id_cnt)
          2'd0:    bus.O_Data = cap_myid;
          2'd1:    bus.O_Data = cap_id_t;
          2'd2:    bus.O_Data = cap_id_f;
          default: bus.O_Data = '0;
        endcase
        if (accept) begin
          if (id_cnt == LAST_ID) begin
            id_cnt_nxt = '0;
            state_nxt  = LD_REQ_ATTRIB;
          end else begin
            id_cnt_nxt = id_cnt + ID_ONE;
          end
        end
      end
      LD_REQ_ATTRIB: begin
        bus.O_Data = cap_attrib;
        if (accept) state_nxt = LD_REQ_RCFG;
      end
      LD_REQ_RCFG: begin
        bus.O_Data = cap_rcfg;
        if (accept) state_nxt = LD_REQ_LENGTH;
      end
      LD_REQ_LENGTH: begin
        bus.O_Data = cap_length;
        if (accept) state_nxt = LD_REQ_STRIDE;
      end
      LD_REQ_STRIDE: begin
        bus.O_Data = cap_stride;
        if (accept) state_nxt = LD_REQ_BASE;
      end
      LD_REQ_BASE: begin
        bus.O_Data = cap_base;
        if (accept) state_nxt = cap_pull ? LD_REQ_REPLY : LD_REQ_RLS;
      end
`ifdef LD_REQ_PULL_EN
      LD_REQ_REPLY: begin
        bus.O_Reply_ID = id_cnt;
        // A terminating reply ends the transfer early, whatever the count.
        if (bus.I_Valid && bus.I_Term) begin
          id_cnt_nxt = '0;
          state_nxt  = LD_REQ_RLS;
        end else if (bus.I_Valid) begin
          if (id_cnt == LAST_ID) begin
            id_cnt_nxt = '0;
            state_nxt  = LD_REQ_DATA;
          end else begin
            id_cnt_nxt = id_cnt + ID_ONE;
          end
        end
      end
      LD_REQ_DATA: begin
        if (bus.I_Valid && bus.I_Term) state_nxt = LD_REQ_RLS;
      end
`endif
      LD_REQ_RLS: begin
        bus.O_Rls = 1'b1;
        if (accept) state_nxt = LD_REQ_DONE;
      end
      LD_REQ_DONE: begin
        O_Done    = 1'b1;
        state_nxt = LD_REQ_INIT;
      end
      default: begin
        id_cnt_nxt = '0;
        state_nxt  = LD_REQ_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_ld_req_issuer.sv
// Directed self-checking bench for ld_req_issuer; pull-phase vectors build only with LD_REQ_PULL_EN.
module tb_ld_req_issuer;

  localparam int WIDTH = 32;

  localparam logic [WIDTH-1:0] V_MYID   = 32'h1D00_0001;
  localparam logic [WIDTH-1:0] V_ID_T   = 32'h1D00_0002;
  localparam logic [WIDTH-1:0] V_ID_F   = 32'h1D00_0003;
  localparam logic [WIDTH-1:0] V_ATTRIB = 32'hA77B_00A0;
  localparam logic [WIDTH-1:0] V_RCFG   = 32'hC0F6_00B0;
  localparam logic [WIDTH-1:0] V_LENGTH = 32'h0000_0040;
  localparam logic [WIDTH-1:0] V_STRIDE = 32'h0000_0008;
  localparam logic [WIDTH-1:0] V_BASE   = 32'h8000_1000;

  logic             clock = 1'b0;
  logic             reset;
  logic             I_Req;
  logic [WIDTH-1:0] I_MyID, I_ID_T, I_ID_F, I_Attrib, I_RConfig, I_Length, I_Stride, I_Base;
  logic             I_PullReq;
  logic             O_Busy, O_Done;

  int n_cmp = 0;
  int n_mis = 0;

  ld_req_issuer_if #(.WIDTH(WIDTH)) bus ();

  ld_req_issuer #(.WIDTH(WIDTH), .NUM_IDS(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .I_Req     (I_Req),
    .I_MyID    (I_MyID),
    .I_ID_T    (I_ID_T),
    .I_ID_F    (I_ID_F),
    .I_Attrib  (I_Attrib),
    .I_RConfig (I_RConfig),
    .I_Length  (I_Length),
    .I_Stride  (I_Stride),
    .I_Base    (I_Base),
    .I_PullReq (I_PullReq),
    .O_Busy    (O_Busy),
    .O_Done    (O_Done),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Token index: 0 Acq, 1..3 IDs, 4..8 descriptor words, 9 Rls.
  function automatic logic [WIDTH-1:0] tok_data(input int k);
    case (k)
      1:       return V_MYID;
      2:       return V_ID_T;
      3:       return V_ID_F;
      4:       return V_ATTRIB;
      5:       return V_RCFG;
      6:       return V_LENGTH;
      7:       return V_STRIDE;
      8:       return V_BASE;
      default: return '0;
    endcase
  endfunction

  task automatic check_tok(input string tag, input int k);
    string t;
    t = $sformatf("%s.t%0d", tag, k);
    check_eq({t, ".valid"}, 64'(bus.O_Valid), 64'd1);
    check_eq({t, ".data"},  64'(bus.O_Data), 64'(tok_data(k)));
    check_eq({t, ".acq"},   64'(bus.O_Acq), 64'(k == 0));
    check_eq({t, ".rls"},   64'(bus.O_Rls), 64'(k == 9));
    check_eq({t, ".busy"},  64'(O_Busy), 64'd1);
    check_eq({t, ".done"},  64'(O_Done), 64'd0);
    check_eq({t, ".rid"},   64'(bus.O_Reply_ID), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".valid"}, 64'(bus.O_Valid), 64'd0);
    check_eq({tag, ".busy"},  64'(O_Busy), 64'd0);
    check_eq({tag, ".done"},  64'(O_Done), 64'd0);
  endtask

  task automatic drive_desc();
    I_MyID = V_MYID;   I_ID_T = V_ID_T;       I_ID_F = V_ID_F;     I_Attrib = V_ATTRIB;
    I_RConfig = V_RCFG; I_Length = V_LENGTH;  I_Stride = V_STRIDE; I_Base = V_BASE;
  endtask

  task automatic scramble_desc();
    I_MyID = ~V_MYID;   I_ID_T = ~V_ID_T;     I_ID_F = ~V_ID_F;     I_Attrib = ~V_ATTRIB;
    I_RConfig = ~V_RCFG; I_Length = ~V_LENGTH; I_Stride = ~V_STRIDE; I_Base = ~V_BASE;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic issue_req(input string tag, input logic pull, input int stall_k,
                           input int stall_n, input bit req_pulse);
    @(negedge clock);
    check_idle({tag, ".pre"});
    drive_desc();
    I_PullReq = pull;
    I_Req     = 1'b1;
    @(negedge clock);
    I_Req     = 1'b0;
    I_PullReq = ~pull;
    scramble_desc();
    for (int k = 0; k < 9; k++) begin
      check_tok(tag, k);
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.I_Stall = 1'b1;
          @(negedge clock);
          check_tok({tag, ".stall"}, k);
        end
        bus.I_Stall = 1'b0;
      end
      if (req_pulse && k == 8) I_Req = 1'b1;
      @(negedge clock);
      I_Req = 1'b0;
    end
`ifdef LD_REQ_PULL_EN
    if (pull) begin
      for (int r = 0; r < 3; r++) begin
        check_eq($sformatf("%s.reply%0d.valid", tag, r), 64'(bus.O_Valid), 64'd0);
        check_eq($sformatf("%s.reply%0d.rid", tag, r), 64'(bus.O_Reply_ID), 64'(r));
        bus.I_Valid = 1'b1;
        bus.I_Data  = 32'h5E00_0000 + 32'(r);
        @(negedge clock);
      end
      for (int d = 0; d < 5; d++) begin
        check_eq($sformatf("%s.data%0d.valid", tag, d), 64'(bus.O_Valid), 64'd0);
        check_eq($sformatf("%s.data%0d.busy", tag, d), 64'(O_Busy), 64'd1);
        bus.I_Valid = 1'b1;
        bus.I_Term  = 1'b0;
        bus.I_Data  = 32'hDA7A_0000 + 32'(d);
        @(negedge clock);
      end
      check_eq({tag, ".data_end.valid"}, 64'(bus.O_Valid), 64'd0);
      bus.I_Term = 1'b1;
      @(negedge clock);
      bus.I_Valid = 1'b0;
      bus.I_Term  = 1'b0;
    end
`endif
    check_tok(tag, 9);
    @(negedge clock);
    check_eq({tag, ".done"},       64'(O_Done), 64'd1);
    check_eq({tag, ".done.valid"}, 64'(bus.O_Valid), 64'd0);
    check_eq({tag, ".done.busy"},  64'(O_Busy), 64'd1);
    if (req_pulse) I_Req = 1'b1;
    @(negedge clock);
    I_Req = 1'b0;
    check_idle({tag, ".post0"});
    @(negedge clock);
    check_idle({tag, ".post1"});
  endtask

  task automatic reset_mid();
    @(negedge clock);
    drive_desc();
    I_PullReq = 1'b0;
    I_Req     = 1'b1;
    @(negedge clock);
    I_Req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_tok("rstmid", k);
      if (k < 7) @(negedge clock);
    end
    #1 reset = 1'b0;
    #1;
    check_eq("rstmid.valid", 64'(bus.O_Valid), 64'd0);
    check_eq("rstmid.busy",  64'(O_Busy), 64'd0);
    check_eq("rstmid.data",  64'(bus.O_Data), 64'd0);
    check_eq("rstmid.done",  64'(O_Done), 64'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    I_Req       = 1'b0;
    I_PullReq   = 1'b0;
    bus.I_Stall = 1'b0;
    bus.I_Valid = 1'b0;
    bus.I_Data  = '0;
    bus.I_Term  = 1'b0;
    drive_desc();
    repeat (2) @(negedge clock);
    check_idle("reset");
    check_eq("reset.data", 64'(bus.O_Data), 64'd0);
    check_eq("reset.acq",  64'(bus.O_Acq), 64'd0);
    check_eq("reset.rls",  64'(bus.O_Rls), 64'd0);
    check_eq("reset.rid",  64'(bus.O_Reply_ID), 64'd0);
    reset = 1'b1;

    issue_req("push", 1'b0, -1, 0, 1'b0);
    issue_req("stall", 1'b0, 6, 4, 1'b0);
    reset_mid();
    issue_req("restart", 1'b0, -1, 0, 1'b0);
    issue_req("ignreq", 1'b0, -1, 0, 1'b1);
`ifdef LD_REQ_PULL_EN
    issue_req("pull", 1'b1, -1, 0, 1'b0);
`else
    issue_req("nopull", 1'b1, -1, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
